// File: rtl/ir_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding and parameter defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ir_fetch_sequencer_pkg;

  // Default widths and special opcodes
  localparam int          ADDR_W_DEF   = 12;
  localparam logic [3:0]  HALT_OP_DEF  = 4'hF;
  localparam int          TIMEOUT_DEF  = 16;
  localparam int          OPCODE_W     = 4;

  // 3-bit state encodings
  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_REQ_ENC    = 3'd1;
  localparam logic [2:0] ST_LOAD_ENC   = 3'd2;
  localparam logic [2:0] ST_DECODE_ENC = 3'd3;
  localparam logic [2:0] ST_EXEC_ENC   = 3'd4;
  localparam logic [2:0] ST_HALTED_ENC = 3'd5;
  localparam logic [2:0] ST_ERROR_ENC  = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_REQ    = ST_REQ_ENC,
    ST_LOAD   = ST_LOAD_ENC,
    ST_DECODE = ST_DECODE_ENC,
    ST_EXEC   = ST_EXEC_ENC,
    ST_HALTED = ST_HALTED_ENC,
    ST_ERROR  = ST_ERROR_ENC
  } state_t;

  // True for the states in which the sequencer is actively working on an instruction
  function automatic logic is_busy_state(input state_t s);
    return (s == ST_REQ) || (s == ST_LOAD) || (s == ST_DECODE) || (s == ST_EXEC);
  endfunction

endpackage

// File: rtl/ir_fetch_sequencer_fetch_timeout_ctr.sv
// Counts cycles spent waiting for a memory acknowledge; flags terminal count at TIMEOUT-1.
// Latency: count updates one cycle after enable; tc is decoded directly from the count register.
// Backpressure: none; the owner clears it whenever it is not waiting.
module fetch_timeout_ctr
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count;

  // Wait counter: clear has priority over counting
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Sequences instruction fetch: PC, req/ack memory read, IR load pulse, execute handshake, branch and halt.
// Latency: 4 cycles per instruction minimum (REQ with same-cycle ack, LOAD, DECODE, one EXEC cycle).
// Backpressure: mem_req held until mem_ack (or timeout); EXEC waits indefinitely for exec_done.
module ir_fetch_sequencer
  import ir_fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = HALT_OP_DEF,
  parameter int                TIMEOUT  = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              load_ir,
  input  logic [3:0]        opcode,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted,
  output logic              fetch_err
);

  state_t state;

  logic   to_clear;
  logic   to_enable;
  logic   to_expired;

  // The wait counter only runs while a request is outstanding and unanswered;
  // an ack on the terminal-count cycle clears it and wins over the timeout.
  assign to_enable = (state == ST_REQ) && !mem_ack;
  assign to_clear  = (state != ST_REQ) || mem_ack;

  fetch_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (to_clear),
    .enable (to_enable),
    .tc     (to_expired)
  );

  // The address bus is the PC register itself, so it always tracks pc.
  assign mem_addr = pc;

  // Control FSM with PC register; every output is a flop set alongside the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      mem_req    <= 1'b0;
      load_ir    <= 1'b0;
      exec_start <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      // Pulsed outputs default low so they last exactly one cycle
      load_ir    <= 1'b0;
      exec_start <= 1'b0;

      case (state)
        ST_IDLE, ST_HALTED, ST_ERROR: begin
          if (start) begin
            state     <= ST_REQ;
            pc        <= RESET_PC;
            mem_req   <= 1'b1;
            busy      <= 1'b1;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
          end
        end

        ST_REQ: begin
          if (mem_ack) begin
            state   <= ST_LOAD;
            mem_req <= 1'b0;
            load_ir <= 1'b1;
          end else if (to_expired) begin
            // Abandon the request; fetch_err stays up until rst or start
            state     <= ST_ERROR;
            mem_req   <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b1;
          end
        end

        ST_LOAD: begin
          // IR captures the word on this edge; its opcode is valid in DECODE
          state <= ST_DECODE;
        end

        ST_DECODE: begin
          if (opcode == HALT_OP) begin
            // pc is left pointing at the halt word
            state  <= ST_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
          end else begin
            state      <= ST_EXEC;
            exec_start <= 1'b1;
          end
        end

        ST_EXEC: begin
          if (exec_done) begin
            if (branch_taken) begin
              pc <= branch_target;
            end else begin
              pc <= pc + ADDR_W'(1);
            end
            state   <= ST_REQ;
            mem_req <= 1'b1;
          end
        end

        default: begin
          state      <= ST_IDLE;
          mem_req    <= 1'b0;
          busy       <= 1'b0;
          halted     <= 1'b0;
          fetch_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed, table-driven check of the fetch sequencer plus hand-written timeout and reset sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_ir_fetch_sequencer;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic        mem_req;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic        load_ir;
  logic [3:0]  opcode;
  logic        exec_start;
  logic        exec_done;
  logic        branch_taken;
  logic [11:0] branch_target;
  logic [11:0] pc;
  logic        busy;
  logic        halted;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  ir_fetch_sequencer #(
    .ADDR_W   (12),
    .RESET_PC (12'h000),
    .HALT_OP  (4'hF),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .load_ir       (load_ir),
    .opcode        (opcode),
    .exec_start    (exec_start),
    .exec_done     (exec_done),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        start;
    logic        ack;
    logic [3:0]  op;
    logic        done;
    logic        br;
    logic [11:0] tgt;
    logic        e_mreq;
    logic [11:0] e_pc;
    logic        e_lir;
    logic        e_xs;
    logic        e_busy;
    logic        e_hlt;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic a, input logic [3:0] op,
                     input logic d, input logic b, input logic [11:0] tgt,
                     input logic mq, input logic [11:0] p, input logic l, input logic x,
                     input logic bz, input logic h, input logic e);
    vec_t v;
    v.rst = r; v.start = s; v.ack = a; v.op = op; v.done = d; v.br = b; v.tgt = tgt;
    v.e_mreq = mq; v.e_pc = p; v.e_lir = l; v.e_xs = x; v.e_busy = bz; v.e_hlt = h; v.e_err = e;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic mq, input logic [11:0] p,
                           input logic l, input logic x, input logic bz,
                           input logic h, input logic e);
    chk({tag, " mem_req"},    {11'd0, mem_req},    {11'd0, mq});
    chk({tag, " pc"},         pc,                  p);
    chk({tag, " mem_addr"},   mem_addr,            p);
    chk({tag, " load_ir"},    {11'd0, load_ir},    {11'd0, l});
    chk({tag, " exec_start"}, {11'd0, exec_start}, {11'd0, x});
    chk({tag, " busy"},       {11'd0, busy},       {11'd0, bz});
    chk({tag, " halted"},     {11'd0, halted},     {11'd0, h});
    chk({tag, " fetch_err"},  {11'd0, fetch_err},  {11'd0, e});
  endtask

  task automatic drive(input logic r, input logic s, input logic a, input logic [3:0] op,
                       input logic d, input logic b, input logic [11:0] tgt);
    rst = r; start = s; mem_ack = a; opcode = op;
    exec_done = d; branch_taken = b; branch_target = tgt;
  endtask

  // Apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic r, input logic s, input logic a, input logic [3:0] op,
                      input logic d, input logic b, input logic [11:0] tgt);
    drive(r, s, a, op, d, b, tgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 12'h000);

    //   rst start ack op    done br tgt       | mreq pc      lir xs busy hlt err
    // reset, then first instruction (ack 1 cycle late, exec_done 2 cycles after exec_start)
    add(1, 0, 0, 4'h0, 0, 0, 12'h000,  0, 12'h000, 0, 0, 0, 0, 0); // 0 IDLE
    add(0, 1, 0, 4'h0, 0, 0, 12'h000,  1, 12'h000, 0, 0, 1, 0, 0); // 1 REQ
    add(0, 0, 0, 4'h0, 0, 0, 12'h000,  1, 12'h000, 0, 0, 1, 0, 0); // 2 REQ wait
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h000, 1, 0, 1, 0, 0); // 3 LOAD
    add(0, 0, 0, 4'h1, 0, 0, 12'h000,  0, 12'h000, 0, 0, 1, 0, 0); // 4 DECODE
    add(0, 0, 0, 4'h1, 0, 0, 12'h000,  0, 12'h000, 0, 1, 1, 0, 0); // 5 EXEC
    add(0, 0, 0, 4'h1, 0, 0, 12'h000,  0, 12'h000, 0, 0, 1, 0, 0); // 6 EXEC wait
    add(0, 0, 0, 4'h1, 1, 0, 12'h000,  1, 12'h001, 0, 0, 1, 0, 0); // 7 REQ @001
    // branch: branch_taken without exec_done has no effect, then taken to 0A5
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h001, 1, 0, 1, 0, 0); // 8 LOAD
    add(0, 0, 0, 4'h2, 0, 0, 12'h000,  0, 12'h001, 0, 0, 1, 0, 0); // 9 DECODE
    add(0, 0, 0, 4'h2, 0, 1, 12'h0A5,  0, 12'h001, 0, 1, 1, 0, 0); // 10 EXEC
    add(0, 0, 0, 4'h2, 0, 1, 12'h0A5,  0, 12'h001, 0, 0, 1, 0, 0); // 11 EXEC, no done
    add(0, 0, 0, 4'h2, 1, 1, 12'h0A5,  1, 12'h0A5, 0, 0, 1, 0, 0); // 12 REQ @0A5
    // branch to FFF, with exec_done outside EXEC and ack outside REQ ignored
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h0A5, 1, 0, 1, 0, 0); // 13 LOAD
    add(0, 0, 0, 4'h3, 1, 1, 12'h123,  0, 12'h0A5, 0, 0, 1, 0, 0); // 14 DECODE, done ignored
    add(0, 0, 1, 4'h3, 0, 0, 12'h000,  0, 12'h0A5, 0, 1, 1, 0, 0); // 15 EXEC, ack ignored
    add(0, 0, 0, 4'h3, 1, 1, 12'hFFF,  1, 12'hFFF, 0, 0, 1, 0, 0); // 16 REQ @FFF
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'hFFF, 1, 0, 1, 0, 0); // 17 LOAD
    add(0, 1, 0, 4'h5, 0, 0, 12'h000,  0, 12'hFFF, 0, 0, 1, 0, 0); // 18 DECODE, start ignored
    add(0, 1, 0, 4'h5, 0, 0, 12'h000,  0, 12'hFFF, 0, 1, 1, 0, 0); // 19 EXEC, start ignored
    add(0, 0, 0, 4'h5, 1, 0, 12'h0A5,  1, 12'h000, 0, 0, 1, 0, 0); // 20 REQ @000 (wrap)
    // program: 3 plain words then HALT at 003
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h000, 1, 0, 1, 0, 0); // 21 LOAD
    add(0, 0, 0, 4'h1, 0, 0, 12'h000,  0, 12'h000, 0, 0, 1, 0, 0); // 22 DECODE
    add(0, 0, 0, 4'h1, 0, 0, 12'h000,  0, 12'h000, 0, 1, 1, 0, 0); // 23 EXEC
    add(0, 0, 0, 4'h1, 1, 0, 12'h000,  1, 12'h001, 0, 0, 1, 0, 0); // 24 REQ @001
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h001, 1, 0, 1, 0, 0); // 25 LOAD
    add(0, 0, 0, 4'h2, 0, 0, 12'h000,  0, 12'h001, 0, 0, 1, 0, 0); // 26 DECODE
    add(0, 0, 0, 4'h2, 0, 0, 12'h000,  0, 12'h001, 0, 1, 1, 0, 0); // 27 EXEC
    add(0, 0, 0, 4'h2, 1, 0, 12'h000,  1, 12'h002, 0, 0, 1, 0, 0); // 28 REQ @002
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h002, 1, 0, 1, 0, 0); // 29 LOAD
    add(0, 0, 0, 4'h4, 0, 0, 12'h000,  0, 12'h002, 0, 0, 1, 0, 0); // 30 DECODE
    add(0, 0, 0, 4'h4, 0, 0, 12'h000,  0, 12'h002, 0, 1, 1, 0, 0); // 31 EXEC
    add(0, 0, 0, 4'h4, 1, 0, 12'h000,  1, 12'h003, 0, 0, 1, 0, 0); // 32 REQ @003
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h003, 1, 0, 1, 0, 0); // 33 LOAD
    add(0, 0, 0, 4'hF, 0, 0, 12'h000,  0, 12'h003, 0, 0, 1, 0, 0); // 34 DECODE
    add(0, 0, 0, 4'hF, 0, 0, 12'h000,  0, 12'h003, 0, 0, 0, 1, 0); // 35 HALTED
    add(0, 0, 1, 4'hF, 1, 0, 12'h000,  0, 12'h003, 0, 0, 0, 1, 0); // 36 HALTED holds
    add(0, 1, 0, 4'h0, 0, 0, 12'h000,  1, 12'h000, 0, 0, 1, 0, 0); // 37 restart REQ @000
    add(0, 0, 1, 4'h0, 0, 0, 12'h000,  0, 12'h000, 1, 0, 1, 0, 0); // 38 LOAD

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].start, vecs[i].ack, vecs[i].op,
           vecs[i].done, vecs[i].br, vecs[i].tgt);
      check_all($sformatf("vec%0d", i), vecs[i].e_mreq, vecs[i].e_pc, vecs[i].e_lir,
                vecs[i].e_xs, vecs[i].e_busy, vecs[i].e_hlt, vecs[i].e_err);
    end

    // Timeout: no ack for TIMEOUT request cycles -> ERROR
    step(1, 0, 0, 4'h0, 0, 0, 12'h000);
    step(0, 1, 0, 4'h0, 0, 0, 12'h000);
    check_all("to_start", 1, 12'h000, 0, 0, 1, 0, 0);
    for (int k = 1; k < TIMEOUT; k++) begin
      step(0, 0, 0, 4'h0, 0, 0, 12'h000);
      check_all($sformatf("to_wait%0d", k), 1, 12'h000, 0, 0, 1, 0, 0);
    end
    step(0, 0, 0, 4'h0, 0, 0, 12'h000);
    check_all("to_error", 0, 12'h000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 4'h0, 1, 0, 12'h000);
    check_all("to_sticky", 0, 12'h000, 0, 0, 0, 0, 1);
    step(0, 1, 0, 4'h0, 0, 0, 12'h000);
    check_all("to_restart", 1, 12'h000, 0, 0, 1, 0, 0);

    // Ack on the terminal-count cycle wins over the timeout
    for (int k = 1; k < TIMEOUT; k++) begin
      step(0, 0, 0, 4'h0, 0, 0, 12'h000);
    end
    check_all("late_pre", 1, 12'h000, 0, 0, 1, 0, 0);
    step(0, 0, 1, 4'h0, 0, 0, 12'h000);
    check_all("late_ack", 0, 12'h000, 1, 0, 1, 0, 0);
    step(0, 0, 0, 4'h0, 0, 0, 12'h000);
    check_all("late_dec", 0, 12'h000, 0, 0, 1, 0, 0);

    // Reset during REQ at a non-zero pc
    step(1, 0, 0, 4'h0, 0, 0, 12'h000);
    step(0, 1, 0, 4'h0, 0, 0, 12'h000);
    step(0, 0, 1, 4'h0, 0, 0, 12'h000);
    step(0, 0, 0, 4'h1, 0, 0, 12'h000);
    step(0, 0, 0, 4'h1, 0, 0, 12'h000);
    step(0, 0, 0, 4'h1, 1, 1, 12'h0A5);
    check_all("rr_req", 1, 12'h0A5, 0, 0, 1, 0, 0);
    step(1, 1, 1, 4'h0, 0, 0, 12'h000);
    check_all("rr_rst", 0, 12'h000, 0, 0, 0, 0, 0);

    // Reset during EXEC overrides a simultaneous exec_done/branch and start
    step(0, 1, 0, 4'h0, 0, 0, 12'h000);
    step(0, 0, 1, 4'h0, 0, 0, 12'h000);
    step(0, 0, 0, 4'h2, 0, 0, 12'h000);
    step(0, 0, 0, 4'h2, 0, 0, 12'h000);
    step(0, 0, 0, 4'h2, 1, 1, 12'h0A5);
    step(0, 0, 1, 4'h0, 0, 0, 12'h000);
    step(0, 0, 0, 4'h2, 0, 0, 12'h000);
    step(0, 0, 0, 4'h2, 0, 0, 12'h000);
    check_all("re_exec", 0, 12'h0A5, 0, 1, 1, 0, 0);
    step(1, 1, 0, 4'h2, 1, 1, 12'h777);
    check_all("re_rst", 0, 12'h000, 0, 0, 0, 0, 0);
    step(0, 0, 1, 4'h0, 1, 0, 12'h000);
    check_all("re_idle", 0, 12'h000, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
